fft_twiddle_sequencer: RTL and testbench

Control block for the radix-2 decimation-in-time FFT datapath. On each accepted start it walks every stage and every butterfly of an N-point FFT. For each butterfly it emits a registered command to the butterfly array over a val/rdy interface: the two sample indices, the stage number and the complex twiddle factor. The twiddle is looked up from the fixed-point sine table driven by the sine-wave generator for the same BIT_WIDTH / DECIMAL_PT / N.

---
 rtl/fft_twiddle_sequencer.sv | 155 +++++++++++++++
 tb/tb_fft_twiddle_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_twiddle_sequencer.sv
// Stage/butterfly walker for a radix-2 DIT FFT.
// Emits one registered index/twiddle command per accepted transfer.
module fft_twiddle_sequencer #(
  parameter  int BIT_WIDTH  = 32,
  parameter  int DECIMAL_PT = 16,
  parameter  int N_SAMPLES  = 32,
  localparam int LOG_N      = $clog2(N_SAMPLES),
  localparam int SW         = (LOG_N > 1) ? $clog2(LOG_N) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] sine_wave_in [N_SAMPLES],
  input  logic                 recv_val,
  output logic                 recv_rdy,
  output logic                 send_val,
  input  logic                 send_rdy,
  output logic [LOG_N-1:0]     send_idx_a,
  output logic [LOG_N-1:0]     send_idx_b,
  output logic [SW-1:0]        send_stage,
  output logic [BIT_WIDTH-1:0] send_tw_re,
  output logic [BIT_WIDTH-1:0] send_tw_im,
  output logic                 send_last,
  output logic                 busy
);

  localparam int BW = LOG_N - 1;

  localparam logic [BW-1:0]    B_LAST = '1;
  localparam logic [SW-1:0]    S_LAST = SW'(LOG_N - 1);
  localparam logic [LOG_N-1:0] QTR    = LOG_N'(N_SAMPLES / 4);

  // A Q-format with no integer bit cannot hold the +1.0 table entries.
  if (DECIMAL_PT >= BIT_WIDTH - 1) begin : g_fmt_too_narrow
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [LOG_N-1:0]     idx_a;
    logic [LOG_N-1:0]     idx_b;
    logic [SW-1:0]        stage;
    logic [BIT_WIDTH-1:0] tw_re;
    logic [BIT_WIDTH-1:0] tw_im;
    logic                 last;
  } cmd_t;

  state_t state_q;
  state_t state_d;

  logic [SW-1:0] s_q;
  logic [SW-1:0] s_d;
  logic [BW-1:0] b_q;
  logic [BW-1:0] b_d;

  logic load;
  logic clear;
  logic at_end;

  cmd_t cmd_q;
  cmd_t cmd_d;

  logic [LOG_N-1:0] bb;
  logic [LOG_N-1:0] half;
  logic [LOG_N-1:0] j;
  logic [LOG_N-1:0] g;
  logic [LOG_N-1:0] ia;
  logic [LOG_N-1:0] k;

  assign at_end = (s_q == S_LAST) && (b_q == B_LAST);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
    load    = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (recv_val) begin
          state_d = RUN;
          s_d     = '0;
          b_d     = '0;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (send_rdy) begin
          load = 1'b1;
          if (at_end) begin
            state_d = IDLE;
            s_d     = '0;
            b_d     = '0;
            clear   = 1'b1;
          end else if (b_q == B_LAST) begin
            b_d = '0;
            s_d = s_q + 1'b1;
          end else begin
            b_d = b_q + 1'b1;
          end
        end
      end
    endcase
  end

  // Command for the (s,b) the counters move to on this edge.
  always_comb begin
    bb   = LOG_N'(b_d);
    half = LOG_N'(1) << s_d;
    j    = bb & (half - 1'b1);
    g    = bb >> s_d;
    ia   = ((g << s_d) << 1) | j;
    k    = j << (S_LAST - s_d);

    cmd_d       = '0;
    cmd_d.idx_a = ia;
    cmd_d.idx_b = ia + half;
    cmd_d.stage = s_d;
    cmd_d.tw_re = sine_wave_in[k + QTR];
    cmd_d.tw_im = '0 - sine_wave_in[k];
    cmd_d.last  = (s_d == S_LAST) && (b_d == B_LAST);
    if (clear) begin
      cmd_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      b_q     <= '0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      b_q     <= b_d;
      if (load) begin
        cmd_q <= cmd_d;
      end
    end
  end

  assign recv_rdy   = (state_q == IDLE);
  assign send_val   = (state_q == RUN);
  assign busy       = (state_q == RUN);
  assign send_idx_a = cmd_q.idx_a;
  assign send_idx_b = cmd_q.idx_b;
  assign send_stage = cmd_q.stage;
  assign send_tw_re = cmd_q.tw_re;
  assign send_tw_im = cmd_q.tw_im;
  assign send_last  = cmd_q.last;

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// Directed bench for fft_twiddle_sequencer, N=32, Q16.16 table.
// Checks the full command stream, stalls, restarts and async reset.
module tb_fft_twiddle_sequencer;

  localparam int N  = 32;
  localparam int NX = 80;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] sine [N];
  logic        recv_val;
  logic        recv_rdy;
  logic        send_val;
  logic        send_rdy;
  logic [4:0]  send_idx_a;
  logic [4:0]  send_idx_b;
  logic [2:0]  send_stage;
  logic [31:0] send_tw_re;
  logic [31:0] send_tw_im;
  logic        send_last;
  logic        busy;

  int total_cnt = 0;
  int bad_cnt   = 0;

  int tbl [N];
  int q   [9] = '{0, 12785, 25079, 36409, 46340,
                  54491, 60547, 64276, 65536};

  int sp_n [7] = '{0, 17, 34, 38, 51, 69, 79};
  int sp_a [7] = '{0, 1, 2, 10, 3, 5, 15};
  int sp_b [7] = '{1, 3, 6, 14, 11, 21, 31};
  int sp_r [7] = '{65536, 0, 0, 0, 25079, 36409, -64276};
  int sp_i [7] = '{0, -65536, -65536, -65536,
                   -60547, -54491, -12785};

  fft_twiddle_sequencer #(
    .BIT_WIDTH (32),
    .DECIMAL_PT(16),
    .N_SAMPLES (N)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sine_wave_in(sine),
    .recv_val    (recv_val),
    .recv_rdy    (recv_rdy),
    .send_val    (send_val),
    .send_rdy    (send_rdy),
    .send_idx_a  (send_idx_a),
    .send_idx_b  (send_idx_b),
    .send_stage  (send_stage),
    .send_tw_re  (send_tw_re),
    .send_tw_im  (send_tw_im),
    .send_last   (send_last),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic void model(input int n, output int ia,
                                output int ib, output int st,
                                output int re, output int im,
                                output int lst);
    int s, b, half, g, jj, k;
    s    = n / (N / 2);
    b    = n % (N / 2);
    half = 1 << s;
    g    = b / half;
    jj   = b % half;
    ia   = g * 2 * half + jj;
    ib   = ia + half;
    st   = s;
    k    = jj * (N / (2 * half));
    re   = tbl[(k + N / 4) % N];
    im   = -tbl[k];
    lst  = (n == NX - 1) ? 1 : 0;
  endfunction

  task automatic check_cmd(input int n);
    int ia, ib, st, re, im, lst, m;
    m = n % NX;
    model(m, ia, ib, st, re, im, lst);
    chk($sformatf("idx_a#%0d", n), send_idx_a, ia);
    chk($sformatf("idx_b#%0d", n), send_idx_b, ib);
    chk($sformatf("stage#%0d", n), send_stage, st);
    chk($sformatf("tw_re#%0d", n),
        longint'($signed(send_tw_re)), re);
    chk($sformatf("tw_im#%0d", n),
        longint'($signed(send_tw_im)), im);
    chk($sformatf("last#%0d", n), send_last, lst);
    for (int i = 0; i < 7; i++) begin
      if (sp_n[i] == m) begin
        chk($sformatf("spot_a#%0d", m), send_idx_a, sp_a[i]);
        chk($sformatf("spot_b#%0d", m), send_idx_b, sp_b[i]);
        chk($sformatf("spot_re#%0d", m),
            longint'($signed(send_tw_re)), sp_r[i]);
        chk($sformatf("spot_im#%0d", m),
            longint'($signed(send_tw_im)), sp_i[i]);
      end
    end
  endtask

  // mode 0: rdy high, 1: random rdy, 2: 3-cycle stall at (2,2)
  task automatic run_xfers(input int total, input int mode);
    int n, cyc, gap, stall, lasts;
    bit rdy;
    n = 0; cyc = 0; gap = 0; stall = 0; lasts = 0;
    while (n < total && cyc < 4000) begin
      if (send_val) begin
        if (gap != 0) chk("idle_gap", gap, 1);
        gap = 0;
        chk("busy_run", busy, 1);
        chk("recv_rdy_run", recv_rdy, 0);
        check_cmd(n);
        rdy = 1'b1;
        if (mode == 1) rdy = ($urandom_range(0, 2) != 0);
        if (mode == 2 && n % NX == 34 && stall < 3) begin
          rdy = 1'b0;
          stall++;
        end
        if (mode == 2 && n % NX == 35) stall = 0;
        send_rdy = rdy;
        if (rdy) begin
          n++;
          if (send_last) lasts++;
        end
      end else begin
        gap++;
        chk("recv_rdy_idle", recv_rdy, 1);
        chk("busy_idle", busy, 0);
        send_rdy = 1'($urandom_range(0, 1));
        recv_val = 1'b1;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    recv_val = 1'b0;
    send_rdy = 1'b0;
    if (n < total) chk("timeout_xfers", n, total);
    chk("last_count", lasts, total / NX);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_recv_rdy"}, recv_rdy, 1);
    chk({tag, "_send_val"}, send_val, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_idx_a"}, send_idx_a, 0);
    chk({tag, "_idx_b"}, send_idx_b, 0);
    chk({tag, "_stage"}, send_stage, 0);
    chk({tag, "_tw_re"}, send_tw_re, 0);
    chk({tag, "_tw_im"}, send_tw_im, 0);
    chk({tag, "_last"}, send_last, 0);
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      int h;
      h = k % (N / 2);
      tbl[k] = (h <= N / 4) ? q[h] : q[N / 2 - h];
      if (k >= N / 2) tbl[k] = -tbl[k];
      sine[k] = tbl[k];
    end

    reset    = 1'b1;
    recv_val = 1'b0;
    send_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("in_reset");
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_idle_zero("after_reset");

    run_xfers(10, 0);
    chk("pre_rst_val", send_val, 1);
    chk("pre_rst_idx_a", send_idx_a, 20);
    #2 reset = 1'b1;
    #1;
    check_idle_zero("async_rst");
    #2 reset = 1'b0;
    @(posedge clk);
    #1;

    run_xfers(NX, 0);
    chk("run1_end_rdy", recv_rdy, 1);
    chk("run1_end_val", send_val, 0);

    run_xfers(2 * NX, 2);
    chk("run2_end_rdy", recv_rdy, 1);
    chk("run2_end_val", send_val, 0);

    run_xfers(3 * NX, 1);
    chk("run3_end_rdy", recv_rdy, 1);
    chk("run3_end_val", send_val, 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
